pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch redirects and multi-cycle data-memory accesses. It runs the data-memory request/acknowledge handshake, detects memory timeouts and keeps a stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the five-stage pipeline.
// Drives the PC and pipeline-register enables/flushes. It handles load-use
// hazards, taken-branch redirects and multi-cycle data-memory accesses with a
// req/ack handshake. It also flags memory timeouts and counts stall cycles.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   ID_rs1/ID_rs2         source registers of the ID instruction
//   ID_use_rs1/ID_use_rs2 ID instruction actually reads rs1/rs2
//   EX_MemRead, EX_rd     EX instruction is a load, and its destination
//   EX_branch_taken       EX resolved a taken branch/jump
//   MEM_access, dmem_ack  MEM instruction touches dmem, dmem completes access
//   dmem_req              data-memory request
//   pc_en, *_en           PC and pipeline-register load enables
//   IF_ID_flush/ID_EX_flush  load a NOP bubble
//   MEM_WB_bubble         MEM/WB captures RegWrite=0, MemtoReg=0
//   mem_err               sticky memory-timeout flag
//   stall_cycles          saturating count of cycles with pc_en=0
module pipe_hazard_ctrl #(
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned MAX_WAIT       = 16,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [REG_ADDR_WIDTH-1:0] ID_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] ID_rs2,
   input  logic                      ID_use_rs1,
   input  logic                      ID_use_rs2,
   input  logic                      EX_MemRead,
   input  logic [REG_ADDR_WIDTH-1:0] EX_rd,
   input  logic                      EX_branch_taken,
   input  logic                      MEM_access,
   input  logic                      dmem_ack,
   output logic                      dmem_req,
   output logic                      pc_en,
   output logic                      IF_ID_en,
   output logic                      ID_EX_en,
   output logic                      EX_MEM_en,
   output logic                      IF_ID_flush,
   output logic                      ID_EX_flush,
   output logic                      MEM_WB_bubble,
   output logic                      mem_err,
   output logic [CNT_WIDTH-1:0]      stall_cycles
);

   // Wait counter only needs to reach MAX_WAIT-1; keep at least one bit.
   localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                set_err;
   logic                mem_hold;
   logic                lu;

   // Load-use hazard: ID reads a register that the load in EX has not yet produced.
   assign lu = EX_MemRead && (EX_rd != '0) &&
               ((ID_use_rs1 && (ID_rs1 == EX_rd)) ||
                (ID_use_rs2 && (ID_rs2 == EX_rd)));

   // State, wait counter, sticky error and stall counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= RUN;
         wait_q       <= '0;
         mem_err      <= 1'b0;
         stall_cycles <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (set_err) begin
            mem_err <= 1'b1;
         end
         if (!pc_en && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
         end
      end
   end

   // Next state and combinational pipeline controls.
   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      set_err       = 1'b0;
      mem_hold      = 1'b0;
      dmem_req      = 1'b0;
      pc_en         = 1'b1;
      IF_ID_en      = 1'b1;
      ID_EX_en      = 1'b1;
      EX_MEM_en     = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EX_flush   = 1'b0;
      MEM_WB_bubble = 1'b0;

      if (rst_n) begin
         unique case (state_q)
            RUN: begin
               dmem_req = MEM_access;
               if (MEM_access && !dmem_ack) begin
                  mem_hold = 1'b1;
                  state_d  = MEM_WAIT;
                  wait_d   = '0;
               end
            end
            MEM_WAIT: begin
               dmem_req = 1'b1;
               if (dmem_ack) begin
                  state_d = RUN;
                  wait_d  = '0;
               end else if (wait_q == WAIT_LAST) begin
                  // Timeout: abandon the access and let the pipeline advance.
                  set_err = 1'b1;
                  state_d = RUN;
                  wait_d  = '0;
               end else begin
                  mem_hold = 1'b1;
                  wait_d   = wait_q + WAIT_W'(1);
               end
            end
            default: begin
               state_d = RUN;
               wait_d  = '0;
            end
         endcase

         // Memory stall freezes everything, so branch/lu wait until it clears.
         if (mem_hold) begin
            pc_en         = 1'b0;
            IF_ID_en      = 1'b0;
            ID_EX_en      = 1'b0;
            EX_MEM_en     = 1'b0;
            MEM_WB_bubble = 1'b1;
         end else if (EX_branch_taken) begin
            // The ID instruction is discarded, so a pending lu is moot.
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
         end else if (lu) begin
            pc_en       = 1'b0;
            IF_ID_en    = 1'b0;
            ID_EX_flush = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: vector table, directed multi-cycle
// sequences and randomized stimulus against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

   localparam int unsigned RW = 5;
   localparam int unsigned MW = 4;
   localparam int unsigned CW = 4;
   localparam int          CMAX = (1 << CW) - 1;

   // Output bundle order: {req, pc, if_id, id_ex, ex_mem, f_ifid, f_idex, bubble}
   localparam logic [7:0] O_IDLE = 8'b0111_1000;
   localparam logic [7:0] O_LU   = 8'b0001_1010;
   localparam logic [7:0] O_BR   = 8'b0111_1110;
   localparam logic [7:0] O_MST  = 8'b1000_0001;
   localparam logic [7:0] O_RST  = 8'b0111_1000;
   localparam logic [7:0] REQ    = 8'b1000_0000;

   logic          clk;
   logic          rst_n;
   logic [RW-1:0] ID_rs1, ID_rs2, EX_rd;
   logic          ID_use_rs1, ID_use_rs2, EX_MemRead, EX_branch_taken;
   logic          MEM_access, dmem_ack;
   logic          dmem_req, pc_en, IF_ID_en, ID_EX_en, EX_MEM_en;
   logic          IF_ID_flush, ID_EX_flush, MEM_WB_bubble, mem_err;
   logic [CW-1:0] stall_cycles;
   logic [7:0]    obs;

   int n_vec = 0;
   int n_bad = 0;

   pipe_hazard_ctrl #(
      .REG_ADDR_WIDTH(RW),
      .MAX_WAIT      (MW),
      .CNT_WIDTH     (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ID_rs1         (ID_rs1),
      .ID_rs2         (ID_rs2),
      .ID_use_rs1     (ID_use_rs1),
      .ID_use_rs2     (ID_use_rs2),
      .EX_MemRead     (EX_MemRead),
      .EX_rd          (EX_rd),
      .EX_branch_taken(EX_branch_taken),
      .MEM_access     (MEM_access),
      .dmem_ack       (dmem_ack),
      .dmem_req       (dmem_req),
      .pc_en          (pc_en),
      .IF_ID_en       (IF_ID_en),
      .ID_EX_en       (ID_EX_en),
      .EX_MEM_en      (EX_MEM_en),
      .IF_ID_flush    (IF_ID_flush),
      .ID_EX_flush    (ID_EX_flush),
      .MEM_WB_bubble  (MEM_WB_bubble),
      .mem_err        (mem_err),
      .stall_cycles   (stall_cycles)
   );

   assign obs = {dmem_req, pc_en, IF_ID_en, ID_EX_en, EX_MEM_en,
                 IF_ID_flush, ID_EX_flush, MEM_WB_bubble};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [RW-1:0] rs1, rs2, rd;
      logic          use1, use2, mrd, br, macc, ack;
      logic [7:0]    exp;
      logic          stl;
   } vec_t;

   vec_t tbl[14];

   function automatic vec_t mkv(input int rs1, input int rs2, input int rd,
                                input bit use1, input bit use2, input bit mrd,
                                input bit br, input bit macc, input bit ack,
                                input logic [7:0] exp, input bit stl);
      vec_t v;
      v.rs1 = RW'(rs1); v.rs2 = RW'(rs2); v.rd = RW'(rd);
      v.use1 = use1; v.use2 = use2; v.mrd = mrd;
      v.br = br; v.macc = macc; v.ack = ack;
      v.exp = exp; v.stl = stl;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic set_in(input vec_t v);
      ID_rs1 = v.rs1; ID_rs2 = v.rs2; EX_rd = v.rd;
      ID_use_rs1 = v.use1; ID_use_rs2 = v.use2; EX_MemRead = v.mrd;
      EX_branch_taken = v.br; MEM_access = v.macc; dmem_ack = v.ack;
   endtask

   task automatic idle_in();
      set_in(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0));
   endtask

   task automatic lu_in();
      ID_rs1 = RW'(1); ID_rs2 = RW'(5); EX_rd = RW'(5);
      ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b1; EX_MemRead = 1'b1;
   endtask

   // One cycle: check outputs mid-cycle, then step past the next posedge.
   task automatic cyc(input string nm, input logic [7:0] exp);
      @(negedge clk);
      chk(nm, int'(obs), int'(exp));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc("rst_out", O_RST);
      cyc("rst_out", O_RST);
      rst_n = 1'b1;
      chk("rst_stall", int'(stall_cycles), 0);
      chk("rst_err", int'(mem_err), 0);
   endtask

   // Reference model: counts stall cycles spent on the current access.
   bit m_busy;
   int m_waited;
   bit m_err;
   int m_stall;

   function automatic bit ref_lu();
      return EX_MemRead && (EX_rd != 0) &&
             ((ID_use_rs1 && ID_rs1 == EX_rd) || (ID_use_rs2 && ID_rs2 == EX_rd));
   endfunction

   initial begin
      int exp_stall;
      logic [7:0] e;
      bit req, hold, tmo;
      bit n_busy, n_err;
      int n_waited, n_stall;

      rst_n = 1'b0;
      idle_in();

      // Power-on reset.
      cyc("por_out", O_RST);
      cyc("por_out", O_RST);
      rst_n = 1'b1;
      chk("por_stall", int'(stall_cycles), 0);
      chk("por_err", int'(mem_err), 0);

      // Single-cycle decisions from RUN.
      tbl[0]  = mkv( 0,  0,  0, 0, 0, 0, 0, 0, 0, O_IDLE,       0);
      tbl[1]  = mkv( 3,  5,  5, 0, 1, 1, 0, 0, 0, O_LU,         1);
      tbl[2]  = mkv( 0,  0,  0, 0, 1, 1, 0, 0, 0, O_IDLE,       0);
      tbl[3]  = mkv( 7,  2,  7, 1, 0, 1, 0, 0, 0, O_LU,         1);
      tbl[4]  = mkv( 7,  2,  7, 0, 0, 1, 0, 0, 0, O_IDLE,       0);
      tbl[5]  = mkv( 7,  2,  7, 1, 0, 0, 0, 0, 0, O_IDLE,       0);
      tbl[6]  = mkv( 4,  6,  5, 1, 1, 1, 0, 0, 0, O_IDLE,       0);
      tbl[7]  = mkv( 0,  0,  0, 0, 0, 0, 1, 0, 0, O_BR,         0);
      tbl[8]  = mkv( 3,  5,  5, 0, 1, 1, 1, 0, 0, O_BR,         0);
      tbl[9]  = mkv( 0,  0,  0, 0, 0, 0, 0, 1, 1, O_IDLE | REQ, 0);
      tbl[10] = mkv( 3,  5,  5, 0, 1, 1, 0, 1, 1, O_LU | REQ,   1);
      tbl[11] = mkv( 0,  0,  0, 0, 0, 0, 0, 0, 1, O_IDLE,       0);
      tbl[12] = mkv( 1,  1,  1, 1, 1, 1, 1, 1, 1, O_BR | REQ,   0);
      tbl[13] = mkv(31, 31, 31, 1, 1, 1, 0, 0, 0, O_LU,         1);

      exp_stall = 0;
      for (int i = 0; i < 14; i++) begin
         set_in(tbl[i]);
         cyc($sformatf("tbl%0d_out", i), tbl[i].exp);
         if (tbl[i].stl) exp_stall++;
         chk($sformatf("tbl%0d_stall", i), int'(stall_cycles), exp_stall);
      end
      idle_in();

      // Access acked 3 cycles after the request.
      do_reset();
      MEM_access = 1'b1;
      for (int i = 0; i < 3; i++) cyc("mw_stall", O_MST);
      dmem_ack = 1'b1;
      cyc("mw_ack", O_IDLE | REQ);
      idle_in();
      chk("mw_stall_cnt", int'(stall_cycles), 3);
      cyc("mw_after", O_IDLE);

      // Branch and lu pending during a memory stall act only on the ack cycle.
      do_reset();
      lu_in();
      EX_branch_taken = 1'b1;
      MEM_access = 1'b1;
      cyc("brh_stall", O_MST);
      cyc("brh_stall", O_MST);
      dmem_ack = 1'b1;
      cyc("brh_ack", O_BR | REQ);
      idle_in();
      cyc("brh_after", O_IDLE);
      chk("brh_stall_cnt", int'(stall_cycles), 2);

      // Timeout after MAX_WAIT cycles in MEM_WAIT; mem_err is sticky.
      do_reset();
      MEM_access = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc("to_stall", O_MST);
         chk("to_err_low", int'(mem_err), 0);
      end
      cyc("to_adv", O_IDLE | REQ);
      chk("to_err_set", int'(mem_err), 1);
      MEM_access = 1'b0;
      for (int i = 0; i < 3; i++) cyc("to_after", O_IDLE);
      chk("to_err_sticky", int'(mem_err), 1);
      chk("to_stall_cnt", int'(stall_cycles), 4);
      do_reset();

      // Saturating stall counter.
      lu_in();
      for (int i = 0; i < 20; i++) cyc("sat_lu", O_LU);
      idle_in();
      chk("sat_cnt", int'(stall_cycles), CMAX);

      // Reset while in MEM_WAIT abandons the access without an error.
      MEM_access = 1'b1;
      cyc("rmw_stall", O_MST);
      cyc("rmw_stall", O_MST);
      do_reset();
      MEM_access = 1'b0;
      cyc("rmw_run", O_IDLE);
      chk("rmw_err", int'(mem_err), 0);
      chk("rmw_stall_cnt", int'(stall_cycles), 0);

      // Randomized stimulus against the reference model.
      m_busy = 0; m_waited = 0; m_err = 0; m_stall = 0;
      for (int i = 0; i < 800; i++) begin
         rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
         ID_rs1 = RW'($urandom_range(0, 3));
         ID_rs2 = RW'($urandom_range(0, 3));
         EX_rd  = RW'($urandom_range(0, 3));
         ID_use_rs1 = 1'($urandom_range(0, 1));
         ID_use_rs2 = 1'($urandom_range(0, 1));
         EX_MemRead = 1'($urandom_range(0, 1));
         EX_branch_taken = ($urandom_range(0, 5) == 0);
         MEM_access = 1'($urandom_range(0, 1));
         dmem_ack = ($urandom_range(0, 2) == 0);

         @(negedge clk);
         n_busy = m_busy; n_waited = m_waited; n_err = m_err; n_stall = m_stall;
         if (!rst_n) begin
            e = O_RST;
            n_busy = 0; n_waited = 0; n_err = 0; n_stall = 0;
         end else begin
            req  = m_busy || MEM_access;
            tmo  = m_busy && !dmem_ack && (m_waited == MW);
            hold = req && !dmem_ack && !tmo;
            if (hold)                 e = O_MST;
            else if (EX_branch_taken) e = O_BR | (req ? REQ : 8'h00);
            else if (ref_lu())        e = O_LU | (req ? REQ : 8'h00);
            else                      e = O_IDLE | (req ? REQ : 8'h00);
            if (hold) begin
               n_busy = 1; n_waited = m_waited + 1;
            end else begin
               if (tmo) n_err = 1;
               n_busy = 0; n_waited = 0;
            end
            if (!e[6] && m_stall < CMAX) n_stall = m_stall + 1;
         end
         chk("rand_out", int'(obs), int'(e));
         @(posedge clk);
         #1;
         m_busy = n_busy; m_waited = n_waited; m_err = n_err; m_stall = n_stall;
         chk("rand_err", int'(mem_err), int'(m_err));
         chk("rand_stall", int'(stall_cycles), m_stall);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
